// File: rtl/alu_multicycle_if.sv
// Request/response bus of the multi-cycle ALU.
//
// Handshake: a request moves when in_valid && in_ready are both high at a
// rising clk edge; a result moves when out_valid && out_ready are both high
// at a rising edge. A producer holds its payload stable while valid is high
// and not yet accepted; valid never depends combinationally on ready.
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [2:0]       ALUControl;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ALUResult;
   logic [3:0]       ALUFlags;
   logic             out_valid;
   logic             out_ready;

   // Requester / result consumer side.
   modport master (
      output SrcA, SrcB, ALUControl, in_valid, out_ready,
      input  in_ready, ALUResult, ALUFlags, out_valid
   );

   // ALU side.
   modport slave (
      input  SrcA, SrcB, ALUControl, in_valid, out_ready,
      output in_ready, ALUResult, ALUFlags, out_valid
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/logic/shift ops, WIDTH-cycle
// shift-add multiplier. Results and {N,Z,C,V} flags are registered and held
// until the consumer takes them; one operation in flight at a time.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_multicycle_if.slave bus,
   output logic [1:0]      state_dbg
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_ORR = 3'b011;
   localparam logic [2:0] OP_EOR = 3'b100;
   localparam logic [2:0] OP_LSL = 3'b101;
   localparam logic [2:0] OP_LSR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

   state_t state, state_nxt;
   logic             ready_en;
   logic             accept;
   logic             mul_last;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, mul_acc_step;
   logic [CW-1:0]    mul_cnt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [WIDTH:0]   add_ext, sub_ext, lsl_ext, lsr_ext;
   logic [7:0]       shamt;

   // ready_en keeps in_ready low until the first edge after reset release.
   assign bus.in_ready  = (state == IDLE) && ready_en;
   assign bus.out_valid = (state == DONE);
   assign bus.ALUResult = result_q;
   assign bus.ALUFlags  = flags_q;
   assign state_dbg     = state;

   assign accept       = bus.in_valid && bus.in_ready;
   assign mul_last     = (mul_cnt == CW'(WIDTH - 1));
   assign mul_acc_step = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
   assign shamt        = bus.SrcB[7:0];

   // Single-cycle datapath; evaluated on the live inputs, sampled at acceptance.
   // The extra bit on each shift captures the last bit shifted out; shifts of
   // zero or beyond WIDTH+1 naturally leave that bit at zero.
   always_comb begin
      add_ext = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
      sub_ext = {1'b0, bus.SrcA} + {1'b0, ~bus.SrcB} + ONE_EXT;
      lsl_ext = {1'b0, bus.SrcA} << shamt;
      lsr_ext = {bus.SrcA, 1'b0} >> shamt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.ALUControl)
         OP_ADD: begin
            alu_res = add_ext[WIDTH-1:0];
            alu_c   = add_ext[WIDTH];
            alu_v   = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) &&
                      (add_ext[WIDTH-1] != bus.SrcA[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_ext[WIDTH-1:0];
            alu_c   = sub_ext[WIDTH];
            alu_v   = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) &&
                      (sub_ext[WIDTH-1] != bus.SrcA[WIDTH-1]);
         end
         OP_AND: alu_res = bus.SrcA & bus.SrcB;
         OP_ORR: alu_res = bus.SrcA | bus.SrcB;
         OP_EOR: alu_res = bus.SrcA ^ bus.SrcB;
         OP_LSL: begin
            alu_res = lsl_ext[WIDTH-1:0];
            alu_c   = lsl_ext[WIDTH];
         end
         OP_LSR: begin
            alu_res = lsr_ext[WIDTH:1];
            alu_c   = lsr_ext[0];
         end
         default: alu_res = '0;
      endcase
   end

   // State register and post-reset ready enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
      end
   end

   // Next-state logic: MUL takes the BUSY path, everything else goes straight to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (bus.ALUControl == OP_MUL) ? BUSY : DONE;
         BUSY: if (mul_last) state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result/flag registers and multiplier; outputs load only on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q   <= '0;
         flags_q    <= 4'b0000;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
         mul_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.ALUControl == OP_MUL) begin
                     mul_acc    <= '0;
                     mul_mcand  <= bus.SrcA;
                     mul_mplier <= bus.SrcB;
                     mul_cnt    <= '0;
                  end else begin
                     result_q <= alu_res;
                     flags_q  <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                  end
               end
            end
            BUSY: begin
               // Last iteration is folded straight into the result register.
               if (mul_last) begin
                  result_q <= mul_acc_step;
                  flags_q  <= {mul_acc_step[WIDTH-1], (mul_acc_step == '0), 2'b00};
               end
               mul_acc    <= mul_acc_step;
               mul_mcand  <= mul_mcand << 1;
               mul_mplier <= mul_mplier >> 1;
               mul_cnt    <= mul_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle at WIDTH=32: fixed vector table, random vectors
// against a reference model, and hand-written backpressure / reset sequences.
module tb_alu_multicycle;
   localparam int WIDTH = 32;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_ORR = 3'd3;
   localparam logic [2:0] OP_EOR = 3'd4, OP_LSL = 3'd5, OP_LSR = 3'd6, OP_MUL = 3'd7;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_BUSY = 2'd1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] res;
      logic [3:0]  flags;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_dbg;
   int         checks;
   int         errors;
   logic [WIDTH+3:0] exp_q[$];
   vec_t       vecs[$];

   alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

   alu_multicycle #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard pop: compares the DUT output against the oldest expectation.
   task automatic check_pop(input string name);
      logic [WIDTH+3:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got result %h", name, bus.ALUResult);
      end else begin
         e = exp_q.pop_front();
         check({name, " result"}, 64'(bus.ALUResult), 64'(e[WIDTH-1:0]));
         check({name, " flags"}, 64'(bus.ALUFlags), 64'(e[WIDTH+3:WIDTH]));
      end
   endtask

   // Reference model, formulated with wide signed/unsigned arithmetic.
   function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      longint      sa, sb, sr;
      logic [63:0] p;
      logic [31:0] r;
      logic        c, v;
      int          s;
      logic [4:0]  idx;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = int'(b[7:0]);
      r  = '0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         OP_ADD: begin
            r  = a + b;
            c  = (r < a);
            sr = sa + sb;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         OP_SUB: begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         OP_AND: r = a & b;
         OP_ORR: r = a | b;
         OP_EOR: r = a ^ b;
         OP_LSL: begin
            if (s == 0) r = a;
            else if (s < 32) begin
               r   = a << s;
               idx = 5'(32 - s);
               c   = a[idx];
            end else if (s == 32) c = a[0];
         end
         OP_LSR: begin
            if (s == 0) r = a;
            else if (s < 32) begin
               r   = a >> s;
               idx = 5'(s - 1);
               c   = a[idx];
            end else if (s == 32) c = a[31];
         end
         default: begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0];
         end
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   // Driver: issue one request, scramble inputs after acceptance, wait for
   // the result and check latency, in_ready while waiting, and the payload.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] er, input logic [3:0] ef, input string tag);
      int lat;
      int guard;
      bit rdy_seen;
      @(negedge clk);
      bus.SrcA = a;
      bus.SrcB = b;
      bus.ALUControl = op;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
      exp_q.push_back({ef, er});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.SrcA = $urandom;
      bus.SrcB = $urandom;
      bus.ALUControl = 3'($urandom_range(0, 7));
      lat = 0;
      rdy_seen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.out_valid && bus.in_ready) rdy_seen = 1'b1;
      end while (!bus.out_valid && lat < 100);
      check({tag, " latency"}, 64'(lat), (op == OP_MUL) ? 64'd33 : 64'd1);
      check({tag, " ready_while_busy"}, 64'(rdy_seen), 64'd0);
      check_pop(tag);
   endtask

   initial begin
      logic [35:0] m;
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      bit          seen;
      checks = 0;
      errors = 0;
      bus.SrcA = '0;
      bus.SrcB = '0;
      bus.ALUControl = OP_ADD;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;

      vecs.push_back('{32'd2, 32'd1, OP_ADD, 32'h3, 4'b0000});
      vecs.push_back('{32'd5, 32'd3, OP_SUB, 32'h2, 4'b0010});
      vecs.push_back('{32'd3, 32'd5, OP_SUB, 32'hFFFFFFFE, 4'b1000});
      vecs.push_back('{32'h7FFFFFFF, 32'd1, OP_ADD, 32'h80000000, 4'b1001});
      vecs.push_back('{32'hFFFFFFFF, 32'd1, OP_ADD, 32'h0, 4'b0110});
      vecs.push_back('{32'd5, 32'd5, OP_SUB, 32'h0, 4'b0110});
      vecs.push_back('{32'h80000000, 32'd1, OP_SUB, 32'h7FFFFFFF, 4'b0011});
      vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, OP_AND, 32'h00F000F0, 4'b0000});
      vecs.push_back('{32'h80000000, 32'd1, OP_ORR, 32'h80000001, 4'b1000});
      vecs.push_back('{32'h12345678, 32'h12345678, OP_EOR, 32'h0, 4'b0100});
      vecs.push_back('{32'd1, 32'd31, OP_LSL, 32'h80000000, 4'b1000});
      vecs.push_back('{32'd1, 32'd32, OP_LSL, 32'h0, 4'b0110});
      vecs.push_back('{32'd3, 32'd1, OP_LSR, 32'h1, 4'b0010});
      vecs.push_back('{32'hFFFFFFFF, 32'd40, OP_LSL, 32'h0, 4'b0100});
      vecs.push_back('{32'hA5A5A5A5, 32'd0, OP_LSL, 32'hA5A5A5A5, 4'b1000});
      vecs.push_back('{32'h80000000, 32'd32, OP_LSR, 32'h0, 4'b0110});
      vecs.push_back('{32'h80000000, 32'd33, OP_LSR, 32'h0, 4'b0100});
      vecs.push_back('{32'd4, 32'h101, OP_LSR, 32'h2, 4'b0000});
      vecs.push_back('{32'd7, 32'd6, OP_MUL, 32'h2A, 4'b0000});
      vecs.push_back('{32'h10000, 32'h10000, OP_MUL, 32'h0, 4'b0100});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL, 32'h1, 4'b0000});

      // Reset: asserted asynchronously, held over several edges.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      repeat (3) @(negedge clk);
      check("rst in_ready", 64'(bus.in_ready), 64'd0);
      check("rst result", 64'(bus.ALUResult), 64'd0);
      check("rst flags", 64'(bus.ALUFlags), 64'd0);
      check("rst state", 64'(state_dbg), 64'(ST_IDLE));
      rst_n = 1'b1;
      #1;
      check("release in_ready before edge", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("release in_ready after edge", 64'(bus.in_ready), 64'd1);

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flags,
                $sformatf("vec%0d", i));

      // Random vectors against the reference model.
      for (int i = 0; i < 12; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (rop == OP_LSL || rop == OP_LSR) ? 32'($urandom_range(0, 40)) : $urandom;
         m   = ref_alu(ra, rb, rop);
         run_op(ra, rb, rop, m[31:0], m[35:32], $sformatf("rnd%0d", i));
      end

      // Backpressure: result held in DONE while in_valid stays high with changing SrcA.
      @(negedge clk);
      bus.SrcA = 32'd10;
      bus.SrcB = 32'd20;
      bus.ALUControl = OP_ADD;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      exp_q.push_back({4'b0000, 32'd30});
      @(posedge clk);
      #1;
      bus.SrcA = $urandom;
      bus.SrcB = 32'd1;
      @(negedge clk);
      check("bp first valid", 64'(bus.out_valid), 64'd1);
      check_pop("bp first");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         bus.SrcA = $urandom;
         @(negedge clk);
         check($sformatf("bp hold%0d valid", k), 64'(bus.out_valid), 64'd1);
         check($sformatf("bp hold%0d result", k), 64'(bus.ALUResult), 64'd30);
         check($sformatf("bp hold%0d flags", k), 64'(bus.ALUFlags), 64'd0);
         check($sformatf("bp hold%0d in_ready", k), 64'(bus.in_ready), 64'd0);
      end
      bus.SrcA = 32'd100;
      bus.SrcB = 32'd1;
      bus.out_ready = 1'b1;
      exp_q.push_back({4'b0000, 32'd101});
      @(negedge clk);
      check("bp idle in_ready", 64'(bus.in_ready), 64'd1);
      check("bp idle out_valid", 64'(bus.out_valid), 64'd0);
      check("bp idle result held", 64'(bus.ALUResult), 64'd30);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("bp second valid", 64'(bus.out_valid), 64'd1);
      check_pop("bp second");

      // Reset in the middle of a MUL: operation aborted, no result pulse.
      @(negedge clk);
      bus.SrcA = 32'd7;
      bus.SrcB = 32'd6;
      bus.ALUControl = OP_MUL;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mulrst busy", 64'(state_dbg), 64'(ST_BUSY));
      rst_n = 1'b0;
      #1;
      check("mulrst out_valid", 64'(bus.out_valid), 64'd0);
      check("mulrst result", 64'(bus.ALUResult), 64'd0);
      check("mulrst flags", 64'(bus.ALUFlags), 64'd0);
      check("mulrst in_ready", 64'(bus.in_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mulrst ready after release", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("mulrst no out_valid", 64'(seen), 64'd0);
      run_op(32'd2, 32'd1, OP_ADD, 32'h3, 4'b0000, "post reset add");

      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port SrcA, input, WIDTH, operand A.
REQ-005 The block SHALL have port SrcB, input, WIDTH, operand B (shift amount = SrcB[7:0] for shifts).
REQ-006 The block SHALL have port ALUControl, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 LSL, 110 LSR, 111 MUL.
REQ-007 The block SHALL have port in_valid, input, 1, request present.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-009 The block SHALL have port ALUResult, output, WIDTH, registered result.
REQ-010 The block SHALL have port ALUFlags, output, 4, registered {N,Z,C,V}, N in bit 3.
REQ-011 The block SHALL have port out_valid, output, 1, ALUResult/ALUFlags valid.
REQ-012 The block SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-014 Acceptance SHALL occur when in_valid&in_ready at a rising edge; SrcA, SrcB, ALUControl captured then; later input changes have no effect on that operation.
REQ-015 Non-MUL ops SHALL go IDLE->DONE; out_valid asserted in the cycle after acceptance (latency 1).
REQ-016 MUL SHALL go IDLE->BUSY, run WIDTH shift-add iterations (one per cycle), then DONE; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-017 In DONE, ALUResult and ALUFlags SHALL be held stable while out_ready=0; DONE&out_ready SHALL return to IDLE next cycle.
REQ-018 in_valid SHALL be ignored in BUSY and DONE (no queuing); requests are never lost only if held until in_ready.
REQ-019 ADD/SUB SHALL compute modulo 2^WIDTH; SUB = A + ~B + 1.
REQ-020 C SHALL be carry-out for ADD, NOT-borrow for SUB (1 when A>=B unsigned); V SHALL be signed overflow for ADD/SUB.
REQ-021 AND/ORR/EOR SHALL set C=0, V=0.
REQ-022 LSL/LSR with shamt=SrcB[7:0]: shamt=0 -> result A, C=0; 1..WIDTH -> C = last bit shifted out; shamt>=WIDTH -> result 0; shamt>WIDTH -> C=0; V=0 always.
REQ-023 MUL SHALL produce the low WIDTH bits of unsigned A*B; C=0, V=0.
REQ-024 For all ops N = ALUResult[WIDTH-1], Z = (ALUResult==0).
REQ-025 Outputs SHALL only change on the edge entering DONE or on reset.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, ALUResult=0, ALUFlags=4'b0000, out_valid=0, in_ready=0 while rst_n is low; in_ready=1 from the first edge after release.
REQ-027 Reset during BUSY or DONE SHALL abort the operation with no out_valid pulse; multiplier state cleared.

Verification (WIDTH=32)
REQ-028 ADD 2+1 -> ALUResult=0x3, flags 0000, out_valid one cycle after acceptance; SUB 5-3 -> 0x2, flags 0010.
REQ-029 SUB 3-5 -> 0xFFFFFFFE, flags 1000; ADD 0x7FFFFFFF+1 -> 0x80000000, flags 1001; ADD 0xFFFFFFFF+1 -> 0x0, flags 0110.
REQ-030 LSL 1 by 31 -> 0x80000000, flags 1000; LSL 0x1 by 32 -> 0x0, flags 0110; LSR 0x3 by 1 -> 0x1, flags 0010; LSL by 40 -> 0x0, flags 0100.
REQ-031 MUL 7*6 -> 0x2A, out_valid exactly 33 cycles after acceptance, in_ready=0 throughout; MUL 0x10000*0x10000 -> 0x0, flags 0100.
REQ-032 Backpressure: out_ready=0 for 5 cycles with in_valid=1 and changing SrcA -> result/flags held, in_ready=0, second request accepted only after return to IDLE and produces its own correct result.
REQ-033 rst_n pulsed low at cycle 10 of a MUL -> out_valid stays 0, outputs 0, in_ready=1 after release; following ADD 2+1 returns 0x3.
